multi_lane_align_collector: RTL
===============================

# multi_lane_align_collector

Parametrised result-side collector for a multi-lane aligner: LANES independent DP + traceback lanes feed alignment beats and end-of-alignment events into per-lane FIFOs. A packet-granular round-robin arbiter merges them into one lane-tagged host stream with valid/ready flow control. It sits between the per-lane traceback outputs and the host interface, replacing direct single-lane alignment_out/alignment_valid/done wiring.

## Interface
- LANES, 4, number of aligner lanes (2..16)
- BP_W, 2, width of one alignment symbol
- POS_W, 16, width of an end-position coordinate
- DEPTH, 8, entries per lane FIFO (power of 2, ≥2)
- LW, $clog2(LANES), lane-index width (derived)
- clk  in  1  clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-low reset
- lane_data  in  LANES*BP_W  alignment symbol per lane; lane i at [i*BP_W +: BP_W]
- lane_valid  in  LANES  lane i alignment symbol valid this cycle
- lane_done  in  LANES  lane i traceback finished; closes lane i's current packet
- lane_pos_x, lane_pos_y  in  LANES*POS_W  lane end position, sampled with lane_done
- lane_ready  out  LANES  lane i FIFO can accept an entry (= not full)
- lane_ovf  out  LANES  sticky: lane i pushed while not ready
- out_valid  out  1  output beat valid
- out_ready  in  1  host accepts beat
- out_lane  out  LW  source lane of beat
- out_data  out  BP_W  alignment symbol
- out_dv  out  1  out_data meaningful
- out_last  out  1  final beat of packet
- out_pos_x, out_pos_y  out  POS_W  end position; meaningful only when out_last=1, else 0

## Operation
- Entry format per lane FIFO: {last, dv, data, pos_x, pos_y}.
- Push, per lane, per cycle (at most one entry): lane_valid only -> {0,1,data,0,0}; lane_done only -> {1,0,0,pos}; both -> {1,1,data,pos}.
- Push while lane_ready=0: entry dropped, lane_ovf[i] set until reset; FIFO unchanged.
- lane_ready derived from registered count only: a full FIFO stays not-ready in a cycle it is popped.
- Arbiter states: IDLE, STREAM. Register rr_ptr (last granted lane), grant.
- IDLE: search lanes rr_ptr+1, rr_ptr+2, … (mod LANES) for first non-empty FIFO; if found, grant<=lane, go STREAM; else stay. out_valid=0 in IDLE.
- STREAM: out_valid = FIFO[grant] non-empty; out_* driven combinationally from FIFO[grant] head. Pop on out_valid&&out_ready. If popped entry has last=1: rr_ptr<=grant, go IDLE.
- Packet-granular: once granted, a lane is held until its last entry pops; empty granted FIFO mid-packet gives out_valid=0 bubbles, no other lane served.
- Pop and push on same FIFO same cycle: count unchanged, both occur.
- out_lane = grant; out_pos_* = 0 when out_last=0.

## Timing
- Reset (async assert): all FIFOs empty, counts 0, state IDLE, rr_ptr=LANES-1 (lane 0 highest priority first), grant=0, lane_ovf=0, lane_ready=all 1, out_valid=0, out_lane/out_data/out_dv/out_last/out_pos_*=0. Reset mid-packet discards all buffered entries.
- Push registered at edge t; entry visible in FIFO from cycle after t.
- Latency: first beat of a packet into empty IDLE collector: out_valid high 2 cycles after push edge (1 cycle IDLE grant decision, then STREAM).
- Throughput: 1 beat/cycle within a packet while FIFO non-empty and out_ready=1; exactly 1 idle cycle between packets.
- out_* stable while out_valid=1 and out_ready=0 (head not popped).
- Wrap-around: FIFO pointers log2(DEPTH) bits, wrap naturally; rr_ptr wraps LANES-1 -> 0.

## Test plan
- Single lane: lane 2 pushes symbols 1,2,3 then lane_done with pos (10,20); out_ready=1 -> beats lane=2 data 1,2,3 dv=1, then last=1 dv=0 pos (10,20); first beat 2 cycles after first push.
- Round-robin: lanes 0,1,3 each hold one complete 2-beat packet, rr_ptr=3 after reset -> served order 0,1,3, one idle cycle between packets, no interleaving.
- Backpressure/full: DEPTH=8, out_ready=0, lane 1 pushes 9 entries -> lane_ready[1]=0 after 8th, 9th dropped, lane_ovf[1]=1 sticky; out_data held stable.
- Combined valid+done: lane 0 lane_valid and lane_done same cycle, data=3, pos (5,7) -> single beat dv=1 last=1 data=3 pos (5,7).
- Mid-packet starvation: lane 0 granted after 1 beat, lane 1 has full packet -> out_valid=0 until lane 0's remaining beats arrive; lane 1 served only after lane 0 last.
- Async reset during STREAM with 3 buffered entries -> outputs and lane_ovf cleared immediately, lane_ready all 1, nothing emitted after release until new pushes.

Source files
------------

// File: rtl/multi_lane_align_collector.sv
// Multi-lane alignment result collector: per-lane FIFOs merged by a
// packet-granular round-robin arbiter into one lane-tagged host stream.
module multi_lane_align_collector #(
   parameter int unsigned LANES = 4,
   parameter int unsigned BP_W  = 2,
   parameter int unsigned POS_W = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned LW    = $clog2(LANES)
) (
   input  logic                   clk,
   input  logic                   reset_i,
   input  logic [LANES*BP_W-1:0]  lane_data,
   input  logic [LANES-1:0]       lane_valid,
   input  logic [LANES-1:0]       lane_done,
   input  logic [LANES*POS_W-1:0] lane_pos_x,
   input  logic [LANES*POS_W-1:0] lane_pos_y,
   output logic [LANES-1:0]       lane_ready,
   output logic [LANES-1:0]       lane_ovf,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LW-1:0]          out_lane,
   output logic [BP_W-1:0]        out_data,
   output logic                   out_dv,
   output logic                   out_last,
   output logic [POS_W-1:0]       out_pos_x,
   output logic [POS_W-1:0]       out_pos_y
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   // Entry layout {last, dv, data, pos_x, pos_y}
   localparam int unsigned EW      = 2 + BP_W + 2 * POS_W;
   localparam int unsigned POSX_LO = POS_W;
   localparam int unsigned DATA_LO = 2 * POS_W;
   localparam int unsigned DV_BIT  = 2 * POS_W + BP_W;
   localparam int unsigned LST_BIT = EW - 1;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   logic [EW-1:0]    mem [LANES][DEPTH];
   logic [AW-1:0]    wr_ptr [LANES];
   logic [AW-1:0]    rd_ptr [LANES];
   logic [CW-1:0]    count [LANES];
   logic [EW-1:0]    push_entry [LANES];
   logic [LANES-1:0] push_req;
   logic [LANES-1:0] push;
   logic [LANES-1:0] pop;
   logic [LANES-1:0] nonempty;
   logic [LANES-1:0] ovf_q;

   state_t           state_q, state_d;
   logic [LW-1:0]    grant_q, grant_d;
   logic [LW-1:0]    rr_q, rr_d;
   logic [EW-1:0]    head;

   assign lane_ovf = ovf_q;

   // Per-lane status derived from registered occupancy, and push entry build
   always_comb begin
      lane_ready = '0;
      nonempty   = '0;
      push_req   = '0;
      push       = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         push_entry[i] = '0;
      end
      for (int i = 0; i < int'(LANES); i++) begin
         lane_ready[i] = (count[i] != CW'(DEPTH));
         nonempty[i]   = (count[i] != '0);
         push_req[i]   = lane_valid[i] | lane_done[i];
         push[i]       = push_req[i] & lane_ready[i];
         push_entry[i] = {lane_done[i], lane_valid[i],
                          lane_valid[i] ? lane_data[i*BP_W +: BP_W] : BP_W'(0),
                          lane_done[i] ? lane_pos_x[i*POS_W +: POS_W] : POS_W'(0),
                          lane_done[i] ? lane_pos_y[i*POS_W +: POS_W] : POS_W'(0)};
      end
   end

   // FIFO pointers, occupancy and sticky overflow flags
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < int'(LANES); i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
            if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
            else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
            if (push_req[i] && !lane_ready[i]) ovf_q[i] <= 1'b1;
         end
      end
   end

   // FIFO storage; contents are don't-care until the matching count says valid
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(LANES); i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= push_entry[i];
      end
   end

   // Arbiter state, granted lane and round-robin pointer
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= LW'(LANES - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
      end
   end

   // Arbiter next-state, lane search, output mux and pop generation
   always_comb begin
      logic          found;
      logic [LW-1:0] sel;
      logic [LW-1:0] cand;
      int unsigned   idx;

      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      pop       = '0;
      out_valid = 1'b0;
      out_lane  = grant_q;
      out_data  = '0;
      out_dv    = 1'b0;
      out_last  = 1'b0;
      out_pos_x = '0;
      out_pos_y = '0;
      found     = 1'b0;
      sel       = '0;
      cand      = '0;
      idx       = 0;
      head      = mem[grant_q][rd_ptr[grant_q]];

      // First non-empty lane after the last granted one
      for (int unsigned k = 1; k <= LANES; k++) begin
         idx  = (32'(rr_q) + k) % LANES;
         cand = LW'(idx);
         if (!found && nonempty[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = sel;
               state_d = STREAM;
            end
         end
         STREAM: begin
            out_valid = nonempty[grant_q];
            if (out_valid) begin
               out_data = head[DATA_LO +: BP_W];
               out_dv   = head[DV_BIT];
               out_last = head[LST_BIT];
               if (head[LST_BIT]) begin
                  out_pos_x = head[POSX_LO +: POS_W];
                  out_pos_y = head[POS_W-1:0];
               end
               if (out_ready) begin
                  pop[grant_q] = 1'b1;
                  if (head[LST_BIT]) begin
                     rr_d    = grant_q;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
